nor_sweep_ctrl: RTL
===================

NOR_SWEEP_CTRL -- requirements
Module: nor_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 2: hold cycles per vector after the first; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: request one truth-table sweep of the NOR unit.
REQ-005 SHALL have port abort, input, 1: cancel a running sweep.
REQ-006 SHALL have port ans_in, input, 1: result from the NOR unit's ans output.
REQ-007 SHALL have port A, output, 1: operand to the NOR unit's A input, registered.
REQ-008 SHALL have port B, output, 1: operand to the NOR unit's B input, registered.
REQ-009 SHALL have port busy, output, 1: sweep in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a sweep completes; no pulse on abort.
REQ-011 SHALL have port pass, output, 1: last completed sweep had zero mismatches.
REQ-012 SHALL have port fail_mask, output, 4: bit i set when vector i mismatched.
REQ-013 SHALL have port err_count, output, 3: number of mismatching vectors, 0..4.

Function
REQ-014 SHALL use states IDLE, RUN and DONE.
REQ-015 SHALL apply this fixed vector table in RUN, as (A,B) -> expected ans: idx0 (0,0)->1, idx1 (1,0)->0, idx2 (0,1)->0, idx3 (1,1)->0.
REQ-016 IDLE: when start=1 at edge E0, SHALL drive A,B to idx0, clear fail_mask and err_count, deassert pass, set busy=1 and enter RUN.
REQ-017 RUN: SHALL hold each vector exactly SETTLE+1 cycles, using a hold counter of width 4.
REQ-018 RUN: SHALL sample ans_in on the last edge of each hold window.
REQ-019 RUN: on the same sample edge, SHALL apply the next vector, or enter DONE after idx3.
REQ-020 A mismatch (ans_in != expected, including X/Z in simulation) SHALL set fail_mask[idx] and increment err_count by 1 (saturating at 4).
REQ-021 Vector k SHALL be applied at edge E0+k*(SETTLE+1) and sampled at edge E0+(k+1)*(SETTLE+1).
REQ-022 SHALL enter DONE at edge E0+4*(SETTLE+1).
REQ-023 DONE: SHALL assert done=1 and busy=0, drive A=B=0, register pass=(err_count==0) including the idx3 result, and return to IDLE next edge.
REQ-024 start while busy=1 or while in DONE SHALL be ignored.
REQ-025 A new sweep SHALL be accepted only in IDLE, i.e. at the earliest one cycle after done.
REQ-026 abort=1 in RUN SHALL return to IDLE on that edge: busy=0, A=B=0, no done, pass=0; fail_mask and err_count keep their partial values.
REQ-027 abort SHALL have no effect in IDLE or DONE.
REQ-028 start and abort both high in IDLE SHALL start a sweep; abort wins in RUN.
REQ-029 pass, fail_mask and err_count SHALL hold their values until the next accepted start.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE with A=0, B=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0 and hold counter 0.
REQ-031 rst SHALL take priority over start and abort, including mid-sweep; an interrupted sweep produces no done.

Structure
REQ-032 Shared package nor_sweep_pkg SHALL hold: the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits), the vector/expected table as constants, and the default SETTLE.
REQ-033 SHALL contain no sub-module; the existing NOR unit stays external and is wired A->A, B->B, ans->ans_in by the integrating top or bench.
REQ-034 SHALL hold all state in one FSM register, one 2-bit vector index and one hold counter.

Verification (SETTLE=2, correct NOR attached unless stated)
REQ-035 Bench SHALL cover: start pulse at E0 -> A,B sequence 00,10,01,11 changing at E0, E0+3, E0+6, E0+9; done high for one cycle after E0+12; pass=1, fail_mask=0000, err_count=0.
REQ-036 Bench SHALL cover: ans_in forced to 0 -> pass=0, fail_mask=0001, err_count=1.
REQ-037 Bench SHALL cover: ans_in tied to 1 -> fail_mask=1110, err_count=3, pass=0.
REQ-038 Bench SHALL cover: abort at E0+5 -> busy=0 and A=B=0 at next cycle, no done, fail_mask=0000, pass=0; new start accepted afterwards and completes with pass=1.
REQ-039 Bench SHALL cover: rst at E0+7 -> all outputs 0 next cycle, no done; start held continuously during RUN is ignored until IDLE.
REQ-040 Bench SHALL cover: SETTLE=1 and SETTLE=15 -> done after E0+8 and E0+64 respectively, pass=1.

Source files
------------

// File: rtl/nor_sweep_pkg.sv
// Shared definitions for the NOR truth-table sweep controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package nor_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SETTLE_DEFAULT = 2;

    // Bit i of each constant belongs to vector i: (0,0)->1, (1,0)->0, (0,1)->0, (1,1)->0
    localparam logic [3:0] VEC_A   = 4'b1010;
    localparam logic [3:0] VEC_B   = 4'b1100;
    localparam logic [3:0] VEC_EXP = 4'b0001;

endpackage

// File: rtl/nor_sweep_ctrl.sv
// Drives the four NOR input vectors, checks ans_in against the expected table and reports pass/fail.
// Latency: done pulses 4*(SETTLE+1) cycles after the accepted start edge.
// Backpressure: none; start is ignored outside IDLE, abort and rst cancel a running sweep.
module nor_sweep_ctrl
    import nor_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       ans_in,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_count
);

    localparam logic [3:0] HOLD_LAST = 4'(SETTLE);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [1:0] idx_inc;
    logic [3:0] hold_cnt;
    logic       sample;
    logic       mismatch;
    logic [2:0] err_nxt;

    assign idx_inc  = idx + 2'd1;
    assign sample   = (hold_cnt == HOLD_LAST);
    // Case inequality so an undriven or X result from the unit counts as a mismatch
    assign mismatch = (ans_in !== VEC_EXP[idx]);
    assign err_nxt  = (mismatch && err_count != 3'd4) ? err_count + 3'd1 : err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (sample && idx == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A         <= 1'b0;
            B         <= 1'b0;
            idx       <= 2'd0;
            hold_cnt  <= 4'd0;
            pass      <= 1'b0;
            fail_mask <= 4'd0;
            err_count <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        A         <= VEC_A[0];
                        B         <= VEC_B[0];
                        idx       <= 2'd0;
                        hold_cnt  <= 4'd0;
                        pass      <= 1'b0;
                        fail_mask <= 4'd0;
                        err_count <= 3'd0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        A        <= 1'b0;
                        B        <= 1'b0;
                        hold_cnt <= 4'd0;
                        pass     <= 1'b0;
                    end else if (sample) begin
                        hold_cnt  <= 4'd0;
                        err_count <= err_nxt;
                        if (mismatch) fail_mask[idx] <= 1'b1;
                        if (idx == 2'd3) begin
                            A    <= 1'b0;
                            B    <= 1'b0;
                            pass <= (err_nxt == 3'd0);
                        end else begin
                            idx <= idx_inc;
                            A   <= VEC_A[idx_inc];
                            B   <= VEC_B[idx_inc];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: begin
                    hold_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule
